// File: rtl/stn_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stn_rx_pkg
// Description : Shared state encoding, geometry defaults and synchronizer
//               bit map for the STN panel receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package stn_rx_pkg;

    localparam int HBYTES_DEF = 40;
    localparam int VLINES_DEF = 240;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SYNC   = 2'd1;
    localparam state_t ST_ACTIVE = 2'd2;

    // Layout of the vector fed to the synchronizer: {fpframe, fpline, fpshift, fpdat}
    localparam int SYNC_W  = 7;
    localparam int B_FRAME = 6;
    localparam int B_LINE  = 5;
    localparam int B_SHIFT = 4;

endpackage : stn_rx_pkg
`default_nettype wire

// File: rtl/stn_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : stn_rx_if
// Description : STN panel strobes/data in, packed pixel byte stream out.
// Revision    : 1.0 - initial release
// ============================================================================
interface stn_rx_if;

    logic       fpframe;
    logic       fpline;
    logic       fpshift;
    logic [3:0] fpdat;

    logic [7:0] o_dat;
    logic       o_vld;
    logic [5:0] o_x;
    logic [7:0] o_y;
    logic       o_sof;
    logic       o_eol;

    // master = panel side / stream consumer, slave = receiver
    modport master (
        output fpframe, fpline, fpshift, fpdat,
        input  o_dat, o_vld, o_x, o_y, o_sof, o_eol
    );

    modport slave (
        input  fpframe, fpline, fpshift, fpdat,
        output o_dat, o_vld, o_x, o_y, o_sof, o_eol
    );

endinterface : stn_rx_if
`default_nettype wire

// File: rtl/stn_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : stn_sync
// Description : Two-flop synchronizer for all seven panel inputs, third stage
//               on the three strobes for edge detection.
// Revision    : 1.0 - initial release
// ============================================================================
module stn_sync
    import stn_rx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [SYNC_W-1:0] async_in,
    output logic [3:0]        dat,
    output logic              frame_rise,
    output logic              line_fall,
    output logic              shift_fall
);

    logic [SYNC_W-1:0] r_s1;
    logic [SYNC_W-1:0] r_s2;
    logic [2:0]        r_s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= async_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2[B_FRAME:B_SHIFT];
        end
    end

    // Data is taken from the same stage as the strobe's new level
    assign dat        = r_s2[3:0];
    assign frame_rise =  r_s2[B_FRAME] & ~r_s3[2];
    assign line_fall  = ~r_s2[B_LINE]  &  r_s3[1];
    assign shift_fall = ~r_s2[B_SHIFT] &  r_s3[0];

endmodule : stn_sync
`default_nettype wire

// File: rtl/stn_rx.sv
`default_nettype none
// ============================================================================
// Module      : stn_rx
// Description : STN panel receiver - packs nibble pairs into bytes with
//               line/frame position and sticky geometry error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module stn_rx
    import stn_rx_pkg::*;
#(
    parameter int HBYTES = HBYTES_DEF,
    parameter int VLINES = VLINES_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         err_clr,
    stn_rx_if.slave      bus,
    output logic         err_h,
    output logic         err_v
);

    localparam logic [6:0] c_hbytes = 7'(HBYTES);
    localparam logic [7:0] c_vlines = 8'(VLINES);

    logic [3:0] w_nib;
    logic       w_frame_rise;
    logic       w_line_fall;
    logic       w_shift_fall;

    stn_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .async_in   ({bus.fpframe, bus.fpline, bus.fpshift, bus.fpdat}),
        .dat        (w_nib),
        .frame_rise (w_frame_rise),
        .line_fall  (w_line_fall),
        .shift_fall (w_shift_fall)
    );

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_active;
    logic       w_armed;

    logic       r_ev_frame;
    logic       r_ev_line;
    logic       r_phase;
    logic [3:0] r_hi;
    logic [7:0] r_dat;
    logic       r_vld;
    logic [5:0] r_x;
    logic [7:0] r_y;
    logic       r_sof;
    logic       r_eol;
    logic       r_err_h;
    logic       r_err_v;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   w_state_nxt = ST_SYNC;
                ST_SYNC:   if (r_ev_frame) w_state_nxt = ST_ACTIVE;
                ST_ACTIVE: w_state_nxt = ST_ACTIVE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_active = en && (r_state == ST_ACTIVE);
        w_armed  = en && ((r_state == ST_SYNC) || (r_state == ST_ACTIVE));
    end

    // Line/frame events are acted on one cycle after detection so that a
    // coincident nibble is packed first, keeping o_x valid during its o_vld.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ev_frame <= 1'b0;
            r_ev_line  <= 1'b0;
        end else begin
            r_ev_frame <= w_frame_rise;
            r_ev_line  <= w_line_fall;
        end
    end

    logic       w_take;
    logic       w_y_over;
    logic       w_nib_drop_v;
    logic       w_nib_drop_h;
    logic       w_nib_store;
    logic       w_line_end;
    logic [6:0] w_line_bytes;
    logic       w_line_bad;
    logic [7:0] w_y_after;
    logic       w_frame;
    logic       w_frame_err;
    logic       w_set_h;
    logic       w_set_v;

    always_comb begin
        w_y_over     = (r_y >= c_vlines);
        w_take       = w_active && w_shift_fall;
        w_nib_drop_v = w_take && w_y_over;
        w_nib_drop_h = w_take && !w_y_over && ({1'b0, r_x} >= c_hbytes);
        w_nib_store  = w_take && !w_nib_drop_v && !w_nib_drop_h;

        w_line_end   = w_active && r_ev_line;
        w_line_bytes = {1'b0, r_x} + {6'd0, r_vld};
        w_line_bad   = w_line_end && !w_y_over &&
                       (r_phase || (w_line_bytes < c_hbytes));
        w_y_after    = (w_line_end && !w_y_over) ? (r_y + 8'd1) : r_y;

        w_frame      = w_armed && r_ev_frame;
        w_frame_err  = w_frame && (r_state == ST_ACTIVE) && (w_y_after != c_vlines);

        w_set_h      = w_nib_drop_h || w_line_bad;
        w_set_v      = w_nib_drop_v || (w_line_end && w_y_over) || w_frame_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= 1'b0;
            r_hi    <= '0;
            r_dat   <= '0;
            r_vld   <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_sof   <= 1'b0;
            r_eol   <= 1'b0;
            r_err_h <= 1'b0;
            r_err_v <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            r_sof <= 1'b0;
            r_eol <= 1'b0;

            if (r_vld) r_x <= r_x + 6'd1;

            if (w_nib_store) begin
                if (!r_phase) begin
                    r_hi    <= w_nib;
                    r_phase <= 1'b1;
                end else begin
                    r_dat   <= {r_hi, w_nib};
                    r_vld   <= 1'b1;
                    r_phase <= 1'b0;
                end
            end

            if (w_line_end) begin
                r_eol   <= 1'b1;
                r_x     <= '0;
                r_phase <= 1'b0;
                r_y     <= w_y_after;
            end

            // Frame restart overrides a coincident line end
            if (w_frame) begin
                r_sof   <= 1'b1;
                r_x     <= '0;
                r_y     <= '0;
                r_phase <= 1'b0;
            end

            r_err_h <= (r_err_h & ~err_clr) | w_set_h;
            r_err_v <= (r_err_v & ~err_clr) | w_set_v;
        end
    end

    assign bus.o_dat = r_dat;
    assign bus.o_vld = r_vld;
    assign bus.o_x   = r_x;
    assign bus.o_y   = r_y;
    assign bus.o_sof = r_sof;
    assign bus.o_eol = r_eol;
    assign err_h     = r_err_h;
    assign err_v     = r_err_v;

endmodule : stn_rx
`default_nettype wire

// File: tb/tb_stn_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_stn_rx
// Description : Directed self-checking bench for stn_rx on a 4-byte x 3-line
//               geometry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stn_rx;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic err_clr;
    logic err_h;
    logic err_v;

    stn_rx_if bus ();

    stn_rx #(.HBYTES(4), .VLINES(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .err_clr (err_clr),
        .bus     (bus),
        .err_h   (err_h),
        .err_v   (err_v)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_sof = 0;
    int n_eol = 0;
    int last_vld_cyc = 0;
    int last_eol_cyc = 0;
    logic [21:0] q_vld[$];

    always @(negedge clk) begin
        cyc++;
        if (bus.o_vld) begin
            q_vld.push_back({bus.o_dat, bus.o_x, bus.o_y});
            last_vld_cyc = cyc;
        end
        if (bus.o_sof) n_sof++;
        if (bus.o_eol) begin
            n_eol++;
            last_eol_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_byte(input string tag, input logic [7:0] d,
                            input logic [5:0] x, input logic [7:0] y);
        logic [21:0] got;
        if (q_vld.size() == 0) got = 22'h3FFFFF;
        else                   got = q_vld.pop_front();
        chk(tag, {10'd0, got}, {10'd0, d, x, y});
    endtask

    task automatic exp_line55(input string tag, input logic [7:0] y);
        for (int x = 0; x < 4; x++) exp_byte(tag, 8'h55, 6'(x), y);
    endtask

    task automatic nib(input logic [3:0] d, input bit with_line);
        bus.fpdat   = d;
        bus.fpshift = 1'b1;
        if (with_line) bus.fpline = 1'b1;
        tick(4);
        bus.fpshift = 1'b0;
        if (with_line) bus.fpline = 1'b0;
        tick(4);
    endtask

    task automatic line_end(input bit with_frame);
        bus.fpline = 1'b1;
        tick(4);
        bus.fpline = 1'b0;
        if (with_frame) bus.fpframe = 1'b1;
        tick(4);
        bus.fpframe = 1'b0;
        tick(4);
    endtask

    task automatic frame_start();
        bus.fpframe = 1'b1;
        tick(4);
        bus.fpframe = 1'b0;
        tick(4);
    endtask

    task automatic line5(input int n);
        for (int i = 0; i < n; i++) nib(4'h5, 1'b0);
        line_end(1'b0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; err_clr = 1'b0;
        bus.fpframe = 1'b0; bus.fpline = 1'b0; bus.fpshift = 1'b0; bus.fpdat = 4'h0;
        tick(3);
        chk("rst_vld",   32'(bus.o_vld), 32'd0);
        chk("rst_sof",   32'(bus.o_sof), 32'd0);
        chk("rst_eol",   32'(bus.o_eol), 32'd0);
        chk("rst_dat",   32'(bus.o_dat), 32'd0);
        chk("rst_x",     32'(bus.o_x),   32'd0);
        chk("rst_y",     32'(bus.o_y),   32'd0);
        chk("rst_err_h", 32'(err_h),     32'd0);
        chk("rst_err_v", 32'(err_v),     32'd0);

        rst = 1'b0; en = 1'b1;
        tick(2);

        // Traffic before any frame start must be ignored
        for (int i = 0; i < 4; i++) nib(4'h7, 1'b0);
        line_end(1'b0);
        tick(4);
        chk("preframe_vld", 32'(q_vld.size()), 32'd0);
        chk("preframe_eol", 32'(n_eol), 32'd0);

        // Frame A: first byte 0x48, last nibble coincident with line fall
        frame_start();
        tick(2);
        chk("A_sof", 32'(n_sof), 32'd1);
        chk("A_y0",  32'(bus.o_y), 32'd0);
        nib(4'h4, 1'b0); nib(4'h8, 1'b0);
        line5(6);
        line5(8);
        for (int i = 0; i < 7; i++) nib(4'h5, 1'b0);
        nib(4'h5, 1'b1);
        tick(6);
        exp_byte("A_first", 8'h48, 6'd0, 8'd0);
        for (int x = 1; x < 4; x++) exp_byte("A_l0", 8'h55, 6'(x), 8'd0);
        exp_line55("A_l1", 8'd1);
        exp_line55("A_l2", 8'd2);
        chk("A_qempty",  32'(q_vld.size()), 32'd0);
        chk("A_eol",     32'(n_eol), 32'd3);
        chk("A_y",       32'(bus.o_y), 32'd3);
        chk("A_x",       32'(bus.o_x), 32'd0);
        chk("A_err_h",   32'(err_h), 32'd0);
        chk("A_err_v",   32'(err_v), 32'd0);
        chk("A_eol_after_vld", 32'(last_eol_cyc > last_vld_cyc), 32'd1);

        // Frame B: overlong line, then an extra line past the frame height
        frame_start();
        tick(2);
        chk("B_sof",   32'(n_sof), 32'd2);
        chk("B_y0",    32'(bus.o_y), 32'd0);
        chk("B_err_v", 32'(err_v), 32'd0);
        for (int i = 1; i <= 9; i++) nib(4'(i), 1'b0);
        line_end(1'b0);
        tick(6);
        exp_byte("B_l0", 8'h12, 6'd0, 8'd0);
        exp_byte("B_l0", 8'h34, 6'd1, 8'd0);
        exp_byte("B_l0", 8'h56, 6'd2, 8'd0);
        exp_byte("B_l0", 8'h78, 6'd3, 8'd0);
        chk("B_long_qempty", 32'(q_vld.size()), 32'd0);
        chk("B_long_err_h",  32'(err_h), 32'd1);
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        chk("B_clr_err_h", 32'(err_h), 32'd0);
        line5(8);
        line5(8);
        tick(6);
        exp_line55("B_l1", 8'd1);
        exp_line55("B_l2", 8'd2);
        chk("B_ok_err_h", 32'(err_h), 32'd0);
        chk("B_ok_err_v", 32'(err_v), 32'd0);
        chk("B_ok_y",     32'(bus.o_y), 32'd3);
        line5(8);
        tick(6);
        chk("B_extra_qempty", 32'(q_vld.size()), 32'd0);
        chk("B_extra_err_v",  32'(err_v), 32'd1);
        chk("B_extra_err_h",  32'(err_h), 32'd0);
        chk("B_extra_y_sat",  32'(bus.o_y), 32'd3);
        chk("B_eol",          32'(n_eol), 32'd7);

        // Frame C: short odd line, then a line whose end coincides with frame rise
        frame_start();
        tick(2);
        chk("C_sof",        32'(n_sof), 32'd3);
        chk("C_y0",         32'(bus.o_y), 32'd0);
        chk("C_err_v_kept", 32'(err_v), 32'd1);
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        chk("C_clr_err_v",  32'(err_v), 32'd0);
        nib(4'hA, 1'b0); nib(4'hB, 1'b0); nib(4'hC, 1'b0); nib(4'hD, 1'b0); nib(4'hE, 1'b0);
        line_end(1'b0);
        tick(6);
        exp_byte("C_short", 8'hAB, 6'd0, 8'd0);
        exp_byte("C_short", 8'hCD, 6'd1, 8'd0);
        chk("C_short_err_h", 32'(err_h), 32'd1);
        chk("C_short_y",     32'(bus.o_y), 32'd1);
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        for (int i = 0; i < 8; i++) nib(4'h5, 1'b0);
        line_end(1'b1);
        tick(6);
        exp_line55("C_l1", 8'd1);
        chk("C_coinc_eol",   32'(n_eol), 32'd9);
        chk("C_coinc_sof",   32'(n_sof), 32'd4);
        chk("C_coinc_y",     32'(bus.o_y), 32'd0);
        chk("C_coinc_err_v", 32'(err_v), 32'd1);
        chk("C_coinc_err_h", 32'(err_h), 32'd0);

        // Frame D: reset in the middle of the second line
        line5(8);
        tick(6);
        exp_line55("D_l0", 8'd0);
        chk("D_y", 32'(bus.o_y), 32'd1);
        nib(4'h9, 1'b0); nib(4'h1, 1'b0); nib(4'h2, 1'b0);
        tick(2);
        exp_byte("D_partial", 8'h91, 6'd0, 8'd1);
        chk("D_x_pre_rst", 32'(bus.o_x), 32'd1);
        rst = 1'b1; tick(1);
        chk("D_rst_x",     32'(bus.o_x), 32'd0);
        chk("D_rst_y",     32'(bus.o_y), 32'd0);
        chk("D_rst_dat",   32'(bus.o_dat), 32'd0);
        chk("D_rst_err_v", 32'(err_v), 32'd0);
        rst = 1'b0; tick(1);
        line5(8);
        tick(6);
        chk("D_post_rst_qempty", 32'(q_vld.size()), 32'd0);
        chk("D_post_rst_eol",    32'(n_eol), 32'd10);
        frame_start();
        tick(2);
        chk("E_sof", 32'(n_sof), 32'd5);
        line5(8);
        tick(6);
        exp_line55("E_l0", 8'd0);
        chk("E_qempty", 32'(q_vld.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_stn_rx
`default_nettype wire
